// File: rtl/mem_pkg.sv
// Shared types for the memory port arbiter: FSM state encoding and the registered bus command.
// Latency: n/a (types only).
// Backpressure: n/a.
package mem_pkg;

    localparam int WORD_ADDR_W = 30;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_FETCH,
        ARB_DATA
    } arb_state_t;

    // Command fields held on the bus for the whole transfer
    typedef struct packed {
        logic                   we;
        logic [WORD_ADDR_W-1:0] addr;
        logic [31:0]            wdata;
    } mem_cmd_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, exe-data and memory-bus signals of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: n/a; master = arbiter side, slave = requesters + memory side.
interface mem_port_arbiter_if;
    import mem_pkg::*;

    // fetch port
    logic                   if_req;
    logic [WORD_ADDR_W-1:0] if_addr;
    logic                   if_ack;
    logic [31:0]            if_rdata;
    // exe data port
    logic                   d_req;
    logic                   d_we;
    logic [31:0]            d_addr;
    logic [31:0]            d_wdata;
    logic                   d_ack;
    logic [31:0]            d_rdata;
    // memory bus
    logic                   bus_req;
    logic                   bus_we;
    logic [WORD_ADDR_W-1:0] bus_addr;
    logic [31:0]            bus_wdata;
    logic                   bus_ack;
    logic [31:0]            bus_rdata;
    // pipeline control / status
    logic                   clk_en;
    logic                   bus_err;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, bus_ack, bus_rdata,
        output if_ack, if_rdata, d_ack, d_rdata,
        output bus_req, bus_we, bus_addr, bus_wdata, clk_en, bus_err
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, bus_ack, bus_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata,
        input  bus_req, bus_we, bus_addr, bus_wdata, clk_en, bus_err
    );

endinterface

// File: rtl/arb_timeout_ctr.sv
// Transfer watchdog: cleared on grant, counts each busy cycle, flags when TIMEOUT-1 is reached.
// Latency: expired_o is combinational from the registered count.
// Backpressure: none. Ports: clk, rst, clr_i (grant), inc_i (transfer busy), expired_o.
module arb_timeout_ctr #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one word-addressed memory bus between instruction fetch and exe loads/stores, with watchdog abort.
// Latency: grant -> bus_req next cycle -> ack pulse one cycle after bus_ack (3 cycles minimum).
// Backpressure: requests are levels held until their ack; clk_en stalls the pipeline while any is owed.
// Ports: clk, rst (sync, active-high), mp (mem_port_arbiter_if.master: fetch, data, bus, clk_en, bus_err).
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int FAIR_LIMIT = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master mp
);

    localparam logic [3:0] FAIR_MAX = 4'(FAIR_LIMIT);

    arb_state_t  state_q, state_d;
    mem_cmd_t    cmd_q, cmd_d;
    logic [3:0]  fair_q, fair_d;
    logic        if_ack_q, if_ack_d;
    logic        d_ack_q, d_ack_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        tmo_clr, tmo_inc, tmo_expired;
    logic        data_wins;
    logic        unused_byte_sel;

    // byte lanes are not used by a word-addressed bus
    assign unused_byte_sel = ^mp.d_addr[1:0];

    assign tmo_inc = (state_q != ARB_IDLE);

    arb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (tmo_clr),
        .inc_i     (tmo_inc),
        .expired_o (tmo_expired)
    );

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        fair_d     = fair_q;
        if_ack_d   = 1'b0;
        d_ack_d    = 1'b0;
        bus_err_d  = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        tmo_clr    = 1'b0;
        // data has priority unless fetch has been passed over FAIR_LIMIT times in a row
        data_wins  = mp.d_req && !(mp.if_req && (fair_q == FAIR_MAX));

        case (state_q)
            ARB_IDLE: begin
                // while an ack is pulsing, that requester's req level is stale: hold off one cycle
                if (!if_ack_q && !d_ack_q) begin
                    if (data_wins) begin
                        state_d = ARB_DATA;
                        cmd_d   = '{we: mp.d_we, addr: mp.d_addr[31:2], wdata: mp.d_wdata};
                        tmo_clr = 1'b1;
                        if (!mp.if_req) begin
                            fair_d = '0;
                        end else if (fair_q != FAIR_MAX) begin
                            fair_d = fair_q + 4'd1;
                        end
                    end else if (mp.if_req) begin
                        state_d = ARB_FETCH;
                        cmd_d   = '{we: 1'b0, addr: mp.if_addr, wdata: 32'h0};
                        tmo_clr = 1'b1;
                        fair_d  = '0;
                    end
                end
            end
            ARB_FETCH, ARB_DATA: begin
                // bus_ack wins over a coincident timeout; an abort returns zero data
                if (mp.bus_ack || tmo_expired) begin
                    state_d   = ARB_IDLE;
                    bus_err_d = !mp.bus_ack;
                    if (state_q == ARB_FETCH) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mp.bus_ack ? mp.bus_rdata : 32'h0;
                    end else begin
                        d_ack_d    = 1'b1;
                        d_rdata_d  = mp.bus_ack ? mp.bus_rdata : 32'h0;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            cmd_q      <= '0;
            fair_q     <= '0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            bus_err_q  <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            fair_q     <= fair_d;
            if_ack_q   <= if_ack_d;
            d_ack_q    <= d_ack_d;
            bus_err_q  <= bus_err_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign mp.bus_req   = (state_q != ARB_IDLE);
    assign mp.bus_we    = cmd_q.we;
    assign mp.bus_addr  = cmd_q.addr;
    assign mp.bus_wdata = cmd_q.wdata;
    assign mp.if_ack    = if_ack_q;
    assign mp.if_rdata  = if_rdata_q;
    assign mp.d_ack     = d_ack_q;
    assign mp.d_rdata   = d_rdata_q;
    assign mp.bus_err   = bus_err_q;
    // a requester is owed service from its req until its ack pulse
    assign mp.clk_en    = !rst && !(mp.d_req && !d_ack_q) && !(mp.if_req && !if_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int FL = 4;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.FAIR_LIMIT(FL), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .mp  (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // transaction-level reference model
    bit          m_busy, m_own_d, m_if_ack, m_d_ack, m_err, m_we;
    int          m_grant_cyc, m_fair;
    logic [29:0] m_addr;
    logic [31:0] m_wdata, m_if_rdata, m_d_rdata;

    // memory responder controls
    bit          mem_on = 1'b1, rsp_rand = 1'b0, rsp_fixed = 1'b1, rsp_done = 1'b0;
    int          rsp_lat = 0, rsp_wait = 0;
    logic [31:0] rsp_val = 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_own_d = 0; m_if_ack = 0; m_d_ack = 0; m_err = 0; m_we = 0;
        m_grant_cyc = 0; m_fair = 0; m_addr = '0; m_wdata = '0;
        m_if_rdata = '0; m_d_rdata = '0;
    endtask

    // advance the model across one clock edge using the inputs held during the cycle before it
    task automatic model_step();
        bit ack_inflight, pick_d;
        if (rst) begin
            model_reset();
            return;
        end
        ack_inflight = m_if_ack || m_d_ack;
        m_if_ack = 0; m_d_ack = 0; m_err = 0;
        if (m_busy) begin
            if (bus.bus_ack || (cyc - m_grant_cyc == TO)) begin
                m_busy = 0;
                m_err  = !bus.bus_ack;
                if (m_own_d) begin
                    m_d_ack = 1; m_d_rdata = bus.bus_ack ? bus.bus_rdata : 32'h0;
                end else begin
                    m_if_ack = 1; m_if_rdata = bus.bus_ack ? bus.bus_rdata : 32'h0;
                end
            end
        end else if (!ack_inflight && (bus.if_req || bus.d_req)) begin
            pick_d = bus.d_req && !(bus.if_req && m_fair == FL);
            m_busy = 1; m_own_d = pick_d; m_grant_cyc = cyc;
            if (pick_d) begin
                m_we = bus.d_we; m_addr = bus.d_addr[31:2]; m_wdata = bus.d_wdata;
                m_fair = bus.if_req ? ((m_fair + 1 > FL) ? FL : m_fair + 1) : 0;
            end else begin
                m_we = 0; m_addr = bus.if_addr; m_fair = 0;
            end
        end
    endtask

    task automatic compare_outputs();
        bit ce;
        ce = !rst && !(bus.d_req && !m_d_ack) && !(bus.if_req && !m_if_ack);
        chk("bus_req",  32'(bus.bus_req),  32'(m_busy));
        chk("bus_we",   32'(bus.bus_we),   32'(m_we));
        chk("bus_addr", 32'(bus.bus_addr), 32'(m_addr));
        if (m_busy && m_own_d) chk("bus_wdata", bus.bus_wdata, m_wdata);
        chk("if_ack",   32'(bus.if_ack),   32'(m_if_ack));
        chk("d_ack",    32'(bus.d_ack),    32'(m_d_ack));
        chk("bus_err",  32'(bus.bus_err),  32'(m_err));
        chk("if_rdata", bus.if_rdata, m_if_rdata);
        chk("d_rdata",  bus.d_rdata,  m_d_rdata);
        chk("clk_en",   32'(bus.clk_en),   32'(ce));
    endtask

    task automatic respond();
        bus.bus_ack = 1'b0;
        if (!bus.bus_req) begin
            rsp_wait = 0; rsp_done = 0;
            if (rsp_rand) begin
                rsp_lat = ($urandom_range(0, 39) == 0) ? 70 : int'($urandom_range(0, 3));
                if ($urandom_range(0, 19) == 0) begin
                    bus.bus_ack = 1'b1; bus.bus_rdata = $urandom;
                end
            end
        end else if (mem_on && !rsp_done) begin
            if (rsp_wait >= rsp_lat) begin
                bus.bus_ack   = 1'b1;
                bus.bus_rdata = rsp_fixed ? rsp_val : $urandom;
                rsp_done      = 1;
            end
            rsp_wait++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        model_step();
        compare_outputs();
        respond();
    endtask

    task automatic drain();
        int n = 0;
        while ((bus.bus_req || bus.if_ack || bus.d_ack) && n < 100) begin
            tick(); n++;
        end
        if (n >= 100) chk("drain_bound", 32'd0, 32'd1);
        tick();
    endtask

    task automatic run_one(input string tag, input bit is_d, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int budget);
        bit seen = 0, got = 0;
        if (is_d) begin
            bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata; bus.d_req = 1'b1;
        end else begin
            bus.if_addr = addr[29:0]; bus.if_req = 1'b1;
        end
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            if (bus.bus_req && !seen) begin
                seen = 1;
                chk({tag, "_addr"}, 32'(bus.bus_addr), 32'(is_d ? addr[31:2] : addr[29:0]));
                chk({tag, "_we"}, 32'(bus.bus_we), 32'(we));
                if (is_d && we) chk({tag, "_wdata"}, bus.bus_wdata, wdata);
            end
            if (is_d ? bus.d_ack : bus.if_ack) begin
                got = 1;
                if (!(is_d && we)) chk({tag, "_rdata"}, is_d ? bus.d_rdata : bus.if_rdata, rdata);
                chk({tag, "_clk_en_ack"}, 32'(bus.clk_en), 32'd1);
            end else begin
                chk({tag, "_clk_en_stall"}, 32'(bus.clk_en), 32'd0);
            end
        end
        if (!got) chk({tag, "_ack_bound"}, 32'd0, 32'd1);
        bus.if_req = 1'b0; bus.d_req = 1'b0;
    endtask

    initial begin
        int          ngr, nreq;
        bit          prev, got;
        logic [9:0]  order;

        bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = '0; bus.d_wdata = '0; bus.bus_ack = 0; bus.bus_rdata = '0;
        model_reset();

        // 1: reset held 3 cycles, then idle
        rst = 1'b1;
        repeat (3) tick();
        chk("t1_clk_en_in_rst", 32'(bus.clk_en), 32'd0);
        rst = 1'b0;
        tick(); tick();
        chk("t1_clk_en", 32'(bus.clk_en), 32'd1);
        chk("t1_bus_req", 32'(bus.bus_req), 32'd0);
        chk("t1_bus_err", 32'(bus.bus_err), 32'd0);

        // 2: fetch, memory acks 2 cycles after bus_req
        rsp_fixed = 1; rsp_val = 32'hDEADBEEF; rsp_lat = 2;
        run_one("t2", 0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 30);
        drain();

        // 3: store
        rsp_val = 32'h0; rsp_lat = 0;
        run_one("t3", 1, 1'b1, 32'h0000_0404, 32'h1234_5678, 32'h0, 30);
        drain();

        // 4: both requesters held, fairness
        rsp_fixed = 0; rsp_lat = 0;
        bus.if_addr = 30'h100; bus.d_addr = 32'h8000_0000; bus.d_we = 0;
        bus.if_req = 1; bus.d_req = 1;
        ngr = 0; order = '0; prev = 0;
        for (int i = 0; i < 200 && ngr < 10; i++) begin
            tick();
            if (bus.bus_req && !prev) begin
                order = {order[8:0], bus.bus_addr[29]};
                ngr++;
            end
            prev = bus.bus_req;
            if (bus.if_ack) bus.if_addr = bus.if_addr + 30'd1;
            if (bus.d_ack)  bus.d_addr  = bus.d_addr + 32'd4;
        end
        chk("t4_grants", 32'(ngr), 32'd10);
        chk("t4_order", 32'(order), 32'(10'b1111011110));
        bus.if_req = 0; bus.d_req = 0;
        drain();

        // 5: memory never answers -> timeout abort
        mem_on = 0;
        bus.d_we = 0; bus.d_addr = 32'h40; bus.d_req = 1;
        nreq = 0; got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            tick();
            if (bus.bus_req) nreq++;
            if (bus.d_ack) begin
                got = 1;
                chk("t5_bus_err", 32'(bus.bus_err), 32'd1);
                chk("t5_d_rdata", bus.d_rdata, 32'h0);
            end
        end
        chk("t5_ack", 32'(got), 32'd1);
        chk("t5_req_cycles", 32'(nreq), 32'd64);
        bus.d_req = 0; mem_on = 1;
        drain();
        rsp_fixed = 1; rsp_val = 32'hCAFEF00D; rsp_lat = 1;
        run_one("t5_next", 0, 1'b0, 32'h55, 32'h0, 32'hCAFEF00D, 30);
        drain();

        // 6: reset in the middle of a data transfer, late ack afterwards
        mem_on = 0;
        bus.d_we = 0; bus.d_addr = 32'h80; bus.d_req = 1;
        for (int i = 0; i < 10 && !bus.bus_req; i++) tick();
        chk("t6_granted", 32'(bus.bus_req), 32'd1);
        tick();
        rst = 1; bus.d_req = 0;
        tick();
        rst = 0; bus.bus_ack = 1; bus.bus_rdata = 32'h5555_AAAA;
        tick();
        chk("t6_d_ack", 32'(bus.d_ack), 32'd0);
        chk("t6_bus_req", 32'(bus.bus_req), 32'd0);
        tick();
        chk("t6_d_ack_late", 32'(bus.d_ack), 32'd0);
        chk("t6_bus_req_late", 32'(bus.bus_req), 32'd0);
        chk("t6_d_rdata", bus.d_rdata, 32'h0);
        mem_on = 1;

        // random traffic against the model
        rsp_rand = 1; rsp_fixed = 0;
        for (int i = 0; i < 1500; i++) begin
            tick();
            rst = ($urandom_range(0, 299) == 0);
            if (bus.if_ack) bus.if_req = 0;
            else if (bus.if_req && m_busy && !m_own_d && $urandom_range(0, 15) == 0) bus.if_req = 0;
            else if (!bus.if_req && $urandom_range(0, 2) == 0) begin
                bus.if_req = 1; bus.if_addr = 30'($urandom);
            end
            if (bus.d_ack) bus.d_req = 0;
            else if (bus.d_req && m_busy && m_own_d && $urandom_range(0, 15) == 0) bus.d_req = 0;
            else if (!bus.d_req && $urandom_range(0, 2) == 0) begin
                bus.d_req = 1; bus.d_we = 1'($urandom);
                bus.d_addr = $urandom; bus.d_wdata = $urandom;
            end
        end
        rst = 0; bus.if_req = 0; bus.d_req = 0; rsp_rand = 0; rsp_lat = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
